// File: rtl/rr_first_one_arb.sv
// Round-robin arbiter: rotating-priority first-one scan with a registered one-hot grant.
// Define RR_ARB_HOLD_EN to keep a grant while its owner is still requesting.
module rr_first_one_arb #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             en,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [2*WIDTH-1:0] dbl;
  logic [IDX_W-1:0]   win;
  logic [WIDTH-1:0]   win_oh;
  logic [IDX_W-1:0]   win_ptr;
  logic               any_req;
  logic               take;

  // Bits ptr+WIDTH down to ptr+1 of {req,req} walk ptr..0,WIDTH-1..ptr+1;
  // the highest set bit at or below ptr+WIDTH is the winner.
  always_comb begin
    dbl     = {req, req};
    win     = '0;
    any_req = |req;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (dbl[i] && (i <= int'(ptr_q) + WIDTH)) begin
        win = IDX_W'(i % WIDTH);
      end
    end
    win_oh  = any_req ? (WIDTH'(1) << win) : '0;
    win_ptr = (win == '0) ? IDX_W'(WIDTH - 1) : win - 1'b1;
  end

`ifdef RR_ARB_HOLD_EN
  logic owner_req;
  assign owner_req = |(req & grant_q);
`endif

  always_comb begin
    grant_d = '0;
    valid_d = 1'b0;
    idx_d   = '0;
    ptr_d   = ptr_q;
    state_d = ST_IDLE;
    take    = 1'b0;
    case (state_q)
      ST_GRANT: begin
`ifdef RR_ARB_HOLD_EN
        if (owner_req) begin
          grant_d = grant_q;
          valid_d = valid_q;
          idx_d   = idx_q;
          state_d = ST_GRANT;
        end else begin
          take = en && any_req;
        end
`else
        take = en && any_req;
`endif
      end
      default: take = en && any_req;
    endcase
    if (take) begin
      grant_d = win_oh;
      valid_d = 1'b1;
      idx_d   = win;
      ptr_d   = win_ptr;
`ifdef RR_ARB_HOLD_EN
      state_d = ST_GRANT;
`else
      state_d = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(WIDTH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_first_one_arb.sv
// Scoreboard bench for rr_first_one_arb at WIDTH=4.
// Directed vectors push expected grants; a negedge monitor pops and compares.
module tb_rr_first_one_arb;

  localparam int W  = 4;
  localparam int IW = 2;

  logic          clk;
  logic          reset;
  logic [W-1:0]  req;
  logic          en;
  logic [W-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  typedef struct {
    int           cyc;
    logic [W-1:0] g;
    string        name;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc;
  int   n_run;
  int   n_fail;

  rr_first_one_arb #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .en         (en),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] oh2idx(input logic [W-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) if (g[i]) r = IW'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] g);
    logic          ev;
    logic [IW-1:0] ei;
    ev = |g;
    ei = oh2idx(g);
    n_run++;
    if (grant !== g || grant_valid !== ev || grant_idx !== ei) begin
      n_fail++;
      $display("FAIL %s: grant=%b valid=%b idx=%0d, expected grant=%b valid=%b idx=%0d",
               name, grant, grant_valid, grant_idx, g, ev, ei);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      chk(m_e.name, m_e.g);
    end
  end

  task automatic step(input string name, input logic [W-1:0] r,
                      input logic e, input logic [W-1:0] g);
    @(posedge clk);
    #1;
    req = r;
    en  = e;
    q.push_back('{cyc: cyc + 1, g: g, name: name});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic areset(input string name);
    drain();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk(name, '0);
    req = '0;
    en  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b0;
    req    = '0;
    en     = 1'b0;
    #3;
    chk("reset_state", '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

`ifndef RR_ARB_HOLD_EN
    step("rr_1111_a", 4'b1111, 1'b1, 4'b1000);
    step("rr_1111_b", 4'b1111, 1'b1, 4'b0100);
    step("rr_1111_c", 4'b1111, 1'b1, 4'b0010);
    step("rr_1111_d", 4'b1111, 1'b1, 4'b0001);
    step("rr_1111_e", 4'b1111, 1'b1, 4'b1000);
    step("en_off_a",  4'b1111, 1'b0, 4'b0000);
    step("en_off_b",  4'b1111, 1'b0, 4'b0000);
    step("en_resume", 4'b1111, 1'b1, 4'b0100);
    step("no_req",    4'b0000, 1'b1, 4'b0000);
    step("after_nr",  4'b1111, 1'b1, 4'b0010);
    areset("async_rst_1");

    step("p0101_a", 4'b0101, 1'b1, 4'b0100);
    step("p0101_b", 4'b0101, 1'b1, 4'b0001);
    step("p0101_c", 4'b0101, 1'b1, 4'b0100);
    step("p0101_d", 4'b0101, 1'b1, 4'b0001);
    step("to_ptr0", 4'b0010, 1'b1, 4'b0010);
    step("wrap",    4'b1010, 1'b1, 4'b1000);
    step("ptr2",    4'b1010, 1'b1, 4'b0010);
`else
    step("hold_a",  4'b0101, 1'b1, 4'b0100);
    step("hold_b",  4'b0101, 1'b0, 4'b0100);
    step("hold_c",  4'b0101, 1'b1, 4'b0100);
    step("hold_d",  4'b0101, 1'b0, 4'b0100);
    step("hold_e",  4'b0101, 1'b1, 4'b0100);
    step("handoff", 4'b0001, 1'b1, 4'b0001);
    step("release", 4'b0000, 1'b1, 4'b0000);
    step("idle_en0", 4'b0001, 1'b0, 4'b0000);
    step("regrant", 4'b0011, 1'b1, 4'b0010);
`endif

    areset("async_rst_2");
    step("post_rst", 4'b1111, 1'b1, 4'b1000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
